muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit for the MIPS core's HI/LO instruction group: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- Extends R-type function decoding to multi-cycle operations, with a busy/done handshake the pipeline control uses to stall.
- Sits beside the ALU in the execute stage and owns the architectural HI/LO registers.

---
 rtl/muldiv_unit_pkg.sv | 27 ++
 rtl/muldiv_unit_step.sv | 47 ++++
 rtl/muldiv_unit.sv | 192 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg
// Shared definitions for the HI/LO multiply/divide unit: R-type function
// codes of the HI/LO instruction group, the group match mask and the FSM
// state encoding.
package muldiv_unit_pkg;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    // (func & HILO_MASK) == HILO_MATCH selects exactly the eight codes above:
    // bits [5:4] = 01 and bit 2 = 0, bits 3/1/0 free.
    localparam logic [5:0] HILO_MASK  = 6'b110100;
    localparam logic [5:0] HILO_MATCH = 6'b010000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_unit_step.sv
// muldiv_step
// One combinational iteration of the iterative multiply/divide datapath.
//   acc      : 2*DATA_WIDTH accumulator. Multiply: {partial product, multiplier}.
//              Divide: {partial remainder, dividend/quotient bits}.
//   operand  : multiplicand (multiply) or divisor (divide), unsigned magnitude.
//   is_div   : 1 = restoring compare-subtract-shift, 0 = radix-2 add-shift.
//   acc_next : accumulator after one iteration.
module muldiv_step
    import muldiv_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2*DATA_WIDTH-1:0] acc,
    input  logic [DATA_WIDTH-1:0]   operand,
    input  logic                    is_div,
    output logic [2*DATA_WIDTH-1:0] acc_next
);

    localparam int W = DATA_WIDTH;

    logic [W:0]   mul_sum;
    logic [W:0]   rem_shift;
    logic [W-1:0] rem_diff;
    logic         rem_ge;

    // Add the multiplicand into the upper half when the current multiplier
    // bit is set; the carry becomes the new MSB after the right shift.
    assign mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operand} : '0);

    // Remainder shifted left by one with the next dividend bit brought in.
    // The remainder is always below the divisor, so the difference fits in W bits.
    assign rem_shift = {acc[2*W-1:W], acc[W-1]};
    assign rem_ge    = rem_shift >= {1'b0, operand};
    assign rem_diff  = rem_shift[W-1:0] - operand;

    always_comb begin
        acc_next = {mul_sum, acc[W-1:1]};
        if (is_div) begin
            if (rem_ge) begin
                acc_next = {rem_diff, acc[W-2:0], 1'b1};
            end else begin
                acc_next = {rem_shift[W-1:0], acc[W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Handles MULT, MULTU, DIV, DIVU (multi-cycle) and MTHI, MTLO, MFHI, MFLO.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_start        : HI/LO-group instruction valid
//   i_function     : R-type function field
//   i_op_a, i_op_b : rs / rt operand values
//   o_busy         : operation in progress (pipeline stall)
//   o_done         : one-cycle pulse when a MULT*/DIV* result is committed
//   o_hi, o_lo     : HI / LO registers
//   o_wrong_instr  : i_start with an unrecognised function (combinational)
//
// state   | meaning
// IDLE    | accepts MT*/MF* and starts MULT*/DIV*
// CALC    | DATA_WIDTH iterations of shift-add / shift-subtract
// FIX     | sign correction, HI/LO write, raises o_done
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int FUNCTION_WIDTH = 6,
    parameter int CNT_WIDTH      = 6
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [FUNCTION_WIDTH-1:0] i_function,
    input  logic [DATA_WIDTH-1:0]     i_op_a,
    input  logic [DATA_WIDTH-1:0]     i_op_b,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [DATA_WIDTH-1:0]     o_hi,
    output logic [DATA_WIDTH-1:0]     o_lo,
    output logic                      o_wrong_instr
);

    localparam int W = DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    state_t state, state_nx;

    logic [CNT_WIDTH-1:0] cnt;
    logic [2*W-1:0]       acc;
    logic [2*W-1:0]       acc_nx;
    logic [W-1:0]         operand;
    logic [W-1:0]         orig_a;
    logic                 op_div;
    logic                 neg_res;
    logic                 neg_rem;
    logic                 div_zero;
    logic [W-1:0]         hi_q, lo_q;
    logic                 done_q;

    // Function decode
    logic fn_group;
    logic is_mthi, is_mtlo, is_mult, is_multu, is_div, is_divu;
    logic is_muldiv, cap_div, cap_signed;
    logic start_ok;

    assign fn_group = (i_function & FUNCTION_WIDTH'(HILO_MASK)) == FUNCTION_WIDTH'(HILO_MATCH);
    assign is_mthi  = i_function == FUNCTION_WIDTH'(FN_MTHI);
    assign is_mtlo  = i_function == FUNCTION_WIDTH'(FN_MTLO);
    assign is_mult  = i_function == FUNCTION_WIDTH'(FN_MULT);
    assign is_multu = i_function == FUNCTION_WIDTH'(FN_MULTU);
    assign is_div   = i_function == FUNCTION_WIDTH'(FN_DIV);
    assign is_divu  = i_function == FUNCTION_WIDTH'(FN_DIVU);

    assign is_muldiv  = is_mult | is_multu | is_div | is_divu;
    assign cap_div    = is_div | is_divu;
    assign cap_signed = is_mult | is_div;

    assign o_wrong_instr = i_start && !fn_group;
    assign start_ok      = i_start && fn_group && (state == ST_IDLE);

    // Operand magnitudes; for unsigned ops the sign flags stay clear.
    logic         a_neg, b_neg;
    logic [W-1:0] abs_a, abs_b;

    assign a_neg = cap_signed & i_op_a[W-1];
    assign b_neg = cap_signed & i_op_b[W-1];
    assign abs_a = a_neg ? -i_op_a : i_op_a;
    assign abs_b = b_neg ? -i_op_b : i_op_b;

    muldiv_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .acc      (acc),
        .operand  (operand),
        .is_div   (op_div),
        .acc_next (acc_nx)
    );

    // Sign correction applied in FIX
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quot_fix, rem_fix;
    logic [W-1:0]   fix_hi, fix_lo;

    always_comb begin
        prod_fix = neg_res ? -acc : acc;
        quot_fix = neg_res ? -acc[W-1:0] : acc[W-1:0];
        rem_fix  = neg_rem ? -acc[2*W-1:W] : acc[2*W-1:W];
        fix_hi   = prod_fix[2*W-1:W];
        fix_lo   = prod_fix[W-1:0];
        if (op_div) begin
            if (div_zero) begin
                fix_hi = orig_a;
                fix_lo = '1;
            end else begin
                fix_hi = rem_fix;
                fix_lo = quot_fix;
            end
        end
    end

    // FSM
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start_ok && is_muldiv) state_nx = ST_CALC;
            ST_CALC: if (cnt == CNT_LAST)       state_nx = ST_FIX;
            ST_FIX:                             state_nx = ST_IDLE;
            default:                            state_nx = ST_IDLE;
        endcase
    end

    // Datapath and HI/LO registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt      <= '0;
            acc      <= '0;
            operand  <= '0;
            orig_a   <= '0;
            op_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        if (is_mthi) hi_q <= i_op_a;
                        if (is_mtlo) lo_q <= i_op_a;
                        if (is_muldiv) begin
                            cnt      <= '0;
                            op_div   <= cap_div;
                            neg_res  <= a_neg ^ b_neg;
                            neg_rem  <= a_neg;
                            div_zero <= cap_div && (i_op_b == '0);
                            orig_a   <= i_op_a;
                            if (cap_div) begin
                                acc     <= {{W{1'b0}}, abs_a};
                                operand <= abs_b;
                            end else begin
                                acc     <= {{W{1'b0}}, abs_b};
                                operand <= abs_a;
                            end
                        end
                    end
                end
                ST_CALC: begin
                    acc <= acc_nx;
                    cnt <= cnt + 1'b1;
                end
                ST_FIX: begin
                    hi_q   <= fix_hi;
                    lo_q   <= fix_lo;
                    done_q <= 1'b1;
                    cnt    <= '0;
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (state != ST_IDLE);
    assign o_done = done_q;
    assign o_hi   = hi_q;
    assign o_lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    localparam int DW = 32;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [5:0]    func = '0;
    logic [DW-1:0] op_a = '0;
    logic [DW-1:0] op_b = '0;
    logic          busy, done, wrong;
    logic [DW-1:0] hi, lo;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.DATA_WIDTH(DW), .FUNCTION_WIDTH(6), .CNT_WIDTH(6)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_function   (func),
        .i_op_a       (op_a),
        .i_op_b       (op_b),
        .o_busy       (busy),
        .o_done       (done),
        .o_hi         (hi),
        .o_lo         (lo),
        .o_wrong_instr(wrong)
    );

    // Reference: plain 64-bit arithmetic with MIPS rules.
    function automatic void ref_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] rh, output logic [31:0] rl);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub;
        logic [63:0]     t, tq, tr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        rh = '0;
        rl = '0;
        case (f)
            F_MULT:  begin t = sa * sb; rh = t[63:32]; rl = t[31:0]; end
            F_MULTU: begin t = ua * ub; rh = t[63:32]; rl = t[31:0]; end
            F_DIV, F_DIVU: begin
                if (b == 32'd0) begin
                    rh = a;
                    rl = '1;
                end else if (f == F_DIV) begin
                    sq = sa / sb; sr = sa % sb;
                    tq = sq; tr = sr;
                    rl = tq[31:0]; rh = tr[31:0];
                end else begin
                    tq = ua / ub; tr = ua % ub;
                    rl = tq[31:0]; rh = tr[31:0];
                end
            end
            default: ;
        endcase
    endfunction

    // Drive a start for one edge; returns at edge+1.
    task automatic drive_start(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; func = f; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Start an op and wait (bounded) for o_done; lat = -1 on timeout.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] rh, output logic [31:0] rl);
        drive_start(f, a, b);
        lat = -1;
        for (int k = 1; k <= DW + 8; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
        end
        rh = hi;
        rl = lo;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (hi !== '0) begin failures++; $display("FAIL reset_hi got=%h want=0", hi); end
        checks++; if (lo !== '0) begin failures++; $display("FAIL reset_lo got=%h want=0", lo); end
        checks++; if (wrong !== 1'b0) begin failures++; $display("FAIL reset_wrong got=%b want=0", wrong); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_timing();
        int n_done;
        bit exp_busy, exp_done;
        n_done = 0;
        drive_start(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int k = 0; k <= DW + 3; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            exp_busy = (k <= DW);
            exp_done = (k == DW + 1);
            if (done) n_done++;
            checks++; if (busy !== exp_busy) begin failures++; $display("FAIL timing_busy edge=%0d got=%b want=%b", k, busy, exp_busy); end
            checks++; if (done !== exp_done) begin failures++; $display("FAIL timing_done edge=%0d got=%b want=%b", k, done, exp_done); end
        end
        checks++; if (n_done != 1) begin failures++; $display("FAIL timing_done_count got=%0d want=1", n_done); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL timing_hi got=%h want=fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin failures++; $display("FAIL timing_lo got=%h want=00000001", lo); end
    endtask

    typedef struct { logic [5:0] f; logic [31:0] a; logic [31:0] b; logic [31:0] eh; logic [31:0] el; } vec_t;

    task automatic test_directed();
        vec_t v[6];
        int lat;
        logic [31:0] rh, rl;
        v[0] = '{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        v[1] = '{F_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
        v[2] = '{F_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        v[3] = '{F_DIVU,  32'd7,         32'd2,         32'd1,         32'd3};
        v[4] = '{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        v[5] = '{F_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
        foreach (v[i]) begin
            run_op(v[i].f, v[i].a, v[i].b, lat, rh, rl);
            checks++; if (lat != DW + 1) begin failures++; $display("FAIL directed%0d_latency got=%0d want=%0d", i, lat, DW + 1); end
            checks++; if (rh !== v[i].eh) begin failures++; $display("FAIL directed%0d_hi got=%h want=%h", i, rh, v[i].eh); end
            checks++; if (rl !== v[i].el) begin failures++; $display("FAIL directed%0d_lo got=%h want=%h", i, rl, v[i].el); end
        end
    endtask

    task automatic test_mt_mf();
        bit saw_busy;
        saw_busy = 0;
        drive_start(F_MTLO, 32'hCAFE_0001, 32'h0);
        if (busy) saw_busy = 1;
        checks++; if (lo !== 32'hCAFE_0001) begin failures++; $display("FAIL mtlo_lo got=%h want=cafe0001", lo); end
        drive_start(F_MTHI, 32'h0000_1234, 32'h0);
        if (busy) saw_busy = 1;
        checks++; if (hi !== 32'h0000_1234) begin failures++; $display("FAIL mthi_hi got=%h want=00001234", hi); end
        checks++; if (lo !== 32'hCAFE_0001) begin failures++; $display("FAIL mthi_lo got=%h want=cafe0001", lo); end
        drive_start(F_MFLO, 32'hDEAD_BEEF, 32'h0);
        if (busy) saw_busy = 1;
        drive_start(F_MFHI, 32'hDEAD_BEEF, 32'h0);
        if (busy) saw_busy = 1;
        @(posedge clk); #1;
        if (busy || done) saw_busy = 1;
        checks++; if (hi !== 32'h0000_1234) begin failures++; $display("FAIL mf_hi got=%h want=00001234", hi); end
        checks++; if (lo !== 32'hCAFE_0001) begin failures++; $display("FAIL mf_lo got=%h want=cafe0001", lo); end
        checks++; if (saw_busy) begin failures++; $display("FAIL mt_mf_busy got=1 want=0"); end
    endtask

    task automatic test_wrong_instr();
        logic [31:0] h0, l0;
        h0 = hi; l0 = lo;
        start = 1'b1; func = 6'b011111; op_a = 32'h5555_AAAA; op_b = 32'h3;
        #1;
        checks++; if (wrong !== 1'b1) begin failures++; $display("FAIL wrong_flag got=%b want=1", wrong); end
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        checks++; if (wrong !== 1'b0) begin failures++; $display("FAIL wrong_no_start got=%b want=0", wrong); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wrong_busy got=%b want=0", busy); end
        checks++; if (hi !== h0 || lo !== l0) begin failures++; $display("FAIL wrong_hilo got=%h/%h want=%h/%h", hi, lo, h0, l0); end
        start = 1'b1; func = F_MTHI; op_a = 32'h1;
        #1;
        checks++; if (wrong !== 1'b0) begin failures++; $display("FAIL wrong_valid_code got=%b want=0", wrong); end
        start = 1'b0;
    endtask

    task automatic test_ignore_busy();
        logic [31:0] a, b, eh, el;
        int lat;
        a = $urandom; b = $urandom;
        ref_model(F_MULT, a, b, eh, el);
        drive_start(F_MULT, a, b);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; func = F_MTLO; op_a = 32'hDEAD_0000; op_b = '0;
        @(posedge clk); #1;
        func = F_MTHI;
        @(posedge clk); #1;
        func = 6'b010111;
        #1;
        checks++; if (wrong !== 1'b1) begin failures++; $display("FAIL busy_wrong_flag got=%b want=1", wrong); end
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int k = 8; k <= DW + 8; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
        end
        checks++; if (lat != DW + 1) begin failures++; $display("FAIL ignore_latency got=%0d want=%0d", lat, DW + 1); end
        checks++; if (hi !== eh) begin failures++; $display("FAIL ignore_hi got=%h want=%h", hi, eh); end
        checks++; if (lo !== el) begin failures++; $display("FAIL ignore_lo got=%h want=%h", lo, el); end
    endtask

    task automatic test_reset_mid();
        int n_done;
        drive_start(F_MTLO, 32'h0000_0055, 32'h0);
        drive_start(F_MTHI, 32'h0000_00AA, 32'h0);
        drive_start(F_MULT, 32'h1234_5678, 32'h0000_0777);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        checks++; if (hi !== '0 || lo !== '0) begin failures++; $display("FAIL rstmid_hilo got=%h/%h want=0/0", hi, lo); end
        n_done = 0;
        for (int k = 0; k < DW + 8; k++) begin
            if (done || busy) n_done++;
            @(posedge clk); #1;
        end
        checks++; if (n_done != 0) begin failures++; $display("FAIL rstmid_activity got=%0d want=0", n_done); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] rh, rl, eh, el;
        run_op(F_DIVU, 32'd1000, 32'd7, lat, rh, rl);
        ref_model(F_DIVU, 32'd1000, 32'd7, eh, el);
        checks++; if (rh !== eh || rl !== el) begin failures++; $display("FAIL b2b_first got=%h/%h want=%h/%h", rh, rl, eh, el); end
        drive_start(F_MULT, 32'hFFFF_8000, 32'h0001_0001);
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL b2b_restart got=done%b/busy%b want=done0/busy1", done, busy); end
        ref_model(F_MULT, 32'hFFFF_8000, 32'h0001_0001, eh, el);
        lat = -1;
        for (int k = 1; k <= DW + 8; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
        end
        checks++; if (lat != DW + 1) begin failures++; $display("FAIL b2b_latency got=%0d want=%0d", lat, DW + 1); end
        checks++; if (hi !== eh || lo !== el) begin failures++; $display("FAIL b2b_second got=%h/%h want=%h/%h", hi, lo, eh, el); end
    endtask

    task automatic test_random();
        logic [5:0]  fl[4];
        logic [5:0]  f;
        logic [31:0] a, b, eh, el, rh, rl;
        int lat;
        fl[0] = F_MULT; fl[1] = F_MULTU; fl[2] = F_DIV; fl[3] = F_DIVU;
        for (int i = 0; i < 30; i++) begin
            f = fl[$urandom_range(0, 3)];
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
                3: b = $urandom_range(1, 255);
                default: ;
            endcase
            ref_model(f, a, b, eh, el);
            run_op(f, a, b, lat, rh, rl);
            checks++; if (lat != DW + 1) begin failures++; $display("FAIL rand%0d_latency f=%b got=%0d want=%0d", i, f, lat, DW + 1); end
            checks++; if (rh !== eh || rl !== el) begin failures++; $display("FAIL rand%0d f=%b a=%h b=%h got=%h/%h want=%h/%h", i, f, a, b, rh, rl, eh, el); end
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_directed();
        test_mt_mf();
        test_wrong_instr();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
